// File: rtl/pixel_writer.sv
// pixel_writer
//   Writes the depth-passed pixel stream into a double-buffered framebuffer
//   RAM. Pixels are queued in a small FIFO (no upstream backpressure, drops
//   are flagged), drained through a stall-able single write port, and the
//   back buffer can be filled with a clear colour. Front/back banks swap on
//   vsync once a finished frame has fully drained.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_color/in_x/in_y pixel stream from the depth-test stage
//   clear_start, clear_color    start a back-buffer fill with clear_color
//   frame_done                  rasteriser finished the current frame
//   vsync                       display is in vertical blank
//   mem_ready                   RAM accepts the current write
//   mem_we/mem_addr/mem_data    write port, mem_addr = {bank, y*FB_WIDTH+x}
//   front_sel                   bank scanned out; writes target ~front_sel
//   swapped                     one-cycle pulse when front_sel toggles
//   overflow                    sticky, an in-range pixel was dropped
//   busy                        work outstanding (FSM, FIFO or write port)
module pixel_writer #(
    parameter int FB_WIDTH   = 160,
    parameter int FB_HEIGHT  = 120,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [11:0]           in_color,
    input  logic [15:0]           in_x,
    input  logic [15:0]           in_y,
    input  logic                  clear_start,
    input  logic [11:0]           clear_color,
    input  logic                  frame_done,
    input  logic                  vsync,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [11:0]           mem_data,
    output logic                  front_sel,
    output logic                  swapped,
    output logic                  overflow,
    output logic                  busy
);
    localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]  CLR_END  = (ADDR_WIDTH + 1)'(FB_DEPTH);
    localparam logic [PTR_W:0]       FIFO_MAX = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [11:0]           color;
        logic [ADDR_WIDTH-1:0] addr;
    } pix_t;

    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN, SWAP_WAIT} state_t;

    state_t                state;
    pix_t                  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic [ADDR_WIDTH:0]   clr_cnt;    // next clear address to issue
    logic [11:0]           clr_color;

    logic                  in_range, fifo_full, fifo_empty;
    logic                  push, drop, pop, out_free;
    logic [ADDR_WIDTH-1:0] pix_addr;
    pix_t                  head;

    // Linear address is computed on entry so the FIFO holds only what the
    // write port needs; the bank bit is added when the word is issued.
    assign in_range   = (in_x < 16'(FB_WIDTH)) && (in_y < 16'(FB_HEIGHT));
    assign pix_addr   = ADDR_WIDTH'(in_y) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(in_x);
    assign fifo_full  = (count == FIFO_MAX);
    assign fifo_empty = (count == '0);
    assign push       = in_valid && in_range && !fifo_full;
    assign drop       = in_valid && in_range && fifo_full;
    // Output register may take a new word when empty or completing this edge.
    assign out_free   = !mem_we || mem_ready;
    assign pop        = ((state == IDLE) || (state == DRAIN)) && !fifo_empty && out_free;
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty || mem_we;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{color: in_color, addr: pix_addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            front_sel <= 1'b0;
            swapped   <= 1'b0;
            overflow  <= 1'b0;
            clr_cnt   <= '0;
            clr_color <= '0;
        end else begin
            swapped <= 1'b0;
            case (state)
                IDLE, DRAIN: begin
                    if (out_free) begin
                        mem_we <= !fifo_empty;
                        if (!fifo_empty) begin
                            mem_addr <= {~front_sel, head.addr};
                            mem_data <= head.color;
                        end
                    end
                    if (state == IDLE) begin
                        if (clear_start) begin
                            state     <= CLEAR;
                            overflow  <= 1'b0;
                            clr_color <= clear_color;
                            clr_cnt   <= '0;
                        end else if (frame_done) begin
                            state <= DRAIN;
                        end
                    end else if (fifo_empty && out_free) begin
                        state <= SWAP_WAIT;
                    end
                end
                CLEAR: begin
                    // A pixel write still pending from IDLE finishes first;
                    // returning to IDLE happens on the edge the last clear
                    // word is accepted.
                    if (out_free) begin
                        if (clr_cnt < CLR_END) begin
                            mem_we   <= 1'b1;
                            mem_addr <= {~front_sel, clr_cnt[ADDR_WIDTH-1:0]};
                            mem_data <= clr_color;
                            clr_cnt  <= clr_cnt + 1'b1;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                SWAP_WAIT: begin
                    if (out_free) mem_we <= 1'b0;
                    if (vsync) begin
                        front_sel <= ~front_sel;
                        swapped   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A drop in the same cycle as a clear start still gets reported.
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;
    typedef struct {
        logic [15:0] addr;
        logic [11:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [11:0] c;
        bit          we;
        logic [15:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_color = '0;
    logic [15:0] in_x = '0, in_y = '0;
    logic        clear_start = 1'b0;
    logic [11:0] clear_color = '0;
    logic        frame_done = 1'b0;
    logic        vsync = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [11:0] mem_data;
    logic        front_sel, swapped, overflow, busy;

    int   checks = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [11:0] prev_data;
    wr_t  sb [$];
    vec_t vt [9];

    always #5 clk = ~clk;

    pixel_writer #(.FB_WIDTH(160), .FB_HEIGHT(120), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_color(in_color), .in_x(in_x), .in_y(in_y),
        .clear_start(clear_start), .clear_color(clear_color),
        .frame_done(frame_done), .vsync(vsync), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .front_sel(front_sel), .swapped(swapped), .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: observe the write port mid-cycle, then step past the edge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_we", 32'(mem_we), 32'd1);
                chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
                chk("stall_data", 32'(mem_data), 32'(prev_data));
            end
            if (mem_we && mem_ready) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    if (failures <= 20)
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                                 mem_addr, mem_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_data), 32'(e.data));
                end
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [11:0] c);
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_color = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base;
        int nexp;

        vt[0] = '{16'd3,     16'd2,   12'hF0A, 1'b1, {1'b1, 15'd323}};
        vt[1] = '{16'd0,     16'd0,   12'h000, 1'b1, {1'b1, 15'd0}};
        vt[2] = '{16'd159,   16'd119, 12'hFFF, 1'b1, {1'b1, 15'd19199}};
        vt[3] = '{16'd160,   16'd0,   12'h111, 1'b0, 16'd0};
        vt[4] = '{16'd0,     16'd120, 12'h222, 1'b0, 16'd0};
        vt[5] = '{16'd65535, 16'd0,   12'h333, 1'b0, 16'd0};
        vt[6] = '{16'd10,    16'd100, 12'h123, 1'b1, {1'b1, 15'd16010}};
        vt[7] = '{16'd159,   16'd0,   12'h456, 1'b1, {1'b1, 15'd159}};
        vt[8] = '{16'd0,     16'd119, 12'h789, 1'b1, {1'b1, 15'd19040}};

        // Reset state
        #12;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_front", 32'(front_sel), 32'd0);
        chk("rst_swapped", 32'(swapped), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single pixel latency and pulse width
        mem_ready = 1'b1;
        sb.push_back('{{1'b1, 15'd323}, 12'hF0A});
        send(3, 2, 12'hF0A);
        chk("lat_we_n", 32'(mem_we), 32'd0);
        tick();
        chk("lat_we_n1", 32'(mem_we), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'h8143);
        chk("lat_data", 32'(mem_data), 32'hF0A);
        tick();
        chk("lat_we_off", 32'(mem_we), 32'd0);
        chk("lat_sb", 32'(sb.size()), 32'd0);

        // Vector table: in-range writes and discarded coordinates
        base = wr_cnt;
        nexp = 0;
        for (int i = 0; i < 9; i++) begin
            if (vt[i].we) begin
                sb.push_back('{vt[i].addr, vt[i].c});
                nexp++;
            end
            send(int'(vt[i].x), int'(vt[i].y), vt[i].c);
        end
        ticks(5);
        chk("tbl_writes", 32'(wr_cnt - base), 32'(nexp));
        chk("tbl_sb", 32'(sb.size()), 32'd0);
        chk("tbl_overflow", 32'(overflow), 32'd0);

        // Stalled port: FIFO + output register hold 17, the 18th drops
        mem_ready = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i < 17) sb.push_back('{{1'b1, 15'(800 + i)}, 12'(12'h100 + i)});
            send(i, 5, 12'(12'h100 + i));
            if (i == 16) chk("ovf_before", 32'(overflow), 32'd0);
            if (i == 17) chk("ovf_after", 32'(overflow), 32'd1);
        end
        chk("stall_head_addr", 32'(mem_addr), 32'(16'h8000 + 16'd800));
        chk("stall_no_writes", 32'(wr_cnt - base), 32'd0);
        mem_ready = 1'b1;
        ticks(25);
        chk("stall_writes", 32'(wr_cnt - base), 32'd17);
        chk("stall_sb", 32'(sb.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full clear with random stalls
        base = wr_cnt;
        for (int i = 0; i < 19200; i++) sb.push_back('{{1'b1, 15'(i)}, 12'h00F});
        clear_color = 12'h00F;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        clear_color = 12'hBAD;
        chk("clr_ovf_cleared", 32'(overflow), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 60000; i++) begin
            if (!busy) break;
            mem_ready = 1'($urandom_range(0, 1));
            tick();
        end
        mem_ready = 1'b1;
        chk("clr_done_busy", 32'(busy), 32'd0);
        chk("clr_writes", 32'(wr_cnt - base), 32'd19200);
        chk("clr_sb", 32'(sb.size()), 32'd0);

        // Out-of-range pixels
        base = wr_cnt;
        send(160, 0, 12'hAAA);
        send(0, 120, 12'hBBB);
        ticks(4);
        chk("oor_writes", 32'(wr_cnt - base), 32'd0);
        chk("oor_overflow", 32'(overflow), 32'd0);

        // vsync outside SWAP_WAIT is ignored
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("vs_idle_front", 32'(front_sel), 32'd0);
        chk("vs_idle_swapped", 32'(swapped), 32'd0);

        // Frame drain then swap on vsync
        base = wr_cnt;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{{1'b1, 15'(320 + 20 + i)}, 12'(12'h500 + i)});
            send(20 + i, 2, 12'(12'h500 + i));
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("swp_no_swap", 32'(swapped), 32'd0);
        end
        chk("swp_writes", 32'(wr_cnt - base), 32'd3);
        chk("swp_front_hold", 32'(front_sel), 32'd0);
        chk("swp_wait_busy", 32'(busy), 32'd1);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("swp_front", 32'(front_sel), 32'd1);
        chk("swp_pulse", 32'(swapped), 32'd1);
        tick();
        chk("swp_pulse_end", 32'(swapped), 32'd0);
        chk("swp_idle_busy", 32'(busy), 32'd0);
        base = wr_cnt;
        sb.push_back('{{1'b0, 15'd161}, 12'h321});
        send(1, 1, 12'h321);
        ticks(4);
        chk("swp_bank0_write", 32'(wr_cnt - base), 32'd1);
        chk("swp_sb", 32'(sb.size()), 32'd0);

        // Reset in the middle of a clear
        base = wr_cnt;
        for (int i = 0; i < 600; i++) sb.push_back('{{1'b0, 15'(i)}, 12'h0F0});
        clear_color = 12'h0F0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (wr_cnt - base >= 500) break;
            tick();
        end
        chk("mid_clr_count", 32'(wr_cnt - base), 32'd500);
        chk("mid_clr_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_data", 32'(mem_data), 32'd0);
        chk("arst_front", 32'(front_sel), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        ticks(2);
        rst_n = 1'b1;
        tick();
        base = wr_cnt;
        sb.push_back('{{1'b1, 15'd7}, 12'hABC});
        send(7, 0, 12'hABC);
        ticks(4);
        chk("post_rst_write", 32'(wr_cnt - base), 32'd1);
        chk("post_rst_sb", 32'(sb.size()), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
